// File: rtl/disp_hex_mux.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned,
// double-buffered display updates and optional leading-zero suppression.
module disp_hex_mux #(
    parameter int N_DIGITS      = 4,
    parameter int PRESCALE_BITS = 18
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*N_DIGITS-1:0]         hex_in,
    input  logic [N_DIGITS-1:0]           dp_in,
    input  logic [N_DIGITS-1:0]           blank_in,
    input  logic                          load,
    input  logic                          lz_en,
    output logic                          load_ack,
    output logic                          pending,
    output logic [N_DIGITS-1:0]           an,
    output logic [3:0]                    hex,
    output logic                          dp,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic [PRESCALE_BITS-1:0]   prescaler;
    logic [IDX_W-1:0]           idx;

    logic [N_DIGITS-1:0][3:0]   stage_hex;
    logic [N_DIGITS-1:0]        stage_dp;
    logic [N_DIGITS-1:0]        stage_blank;
    logic [N_DIGITS-1:0][3:0]   disp_hex;
    logic [N_DIGITS-1:0]        disp_dp;
    logic [N_DIGITS-1:0]        disp_blank;

    logic                       tick;
    logic                       frame_end;
    logic                       commit;
    logic                       zero_run;
    logic [N_DIGITS-1:0]        lz_dark;
    logic [N_DIGITS-1:0]        dark;
    logic [N_DIGITS-1:0]        an_next;

    always_comb begin
        tick      = &prescaler;
        frame_end = tick && (idx == LAST_IDX);
        commit    = frame_end && pending;
    end

    // A digit is a leading zero when it and every digit above it show a
    // zero nibble with the decimal point off; digit 0 always stays lit.
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (disp_hex[d] == 4'h0) && disp_dp[d];
            if (d != 0) begin
                lz_dark[d] = lz_en && zero_run;
            end
        end
        dark    = disp_blank | lz_dark;
        an_next = '1;
        if (!dark[idx]) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Commit reads staging before this cycle's load overwrites it, so a load
    // on the frame_end cycle stays pending for the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_hex   <= '0;
            stage_dp    <= '1;
            stage_blank <= '0;
            disp_hex    <= '0;
            disp_dp     <= '1;
            disp_blank  <= '0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            load_ack <= commit;
            if (commit) begin
                disp_hex   <= stage_hex;
                disp_dp    <= stage_dp;
                disp_blank <= stage_blank;
            end
            if (load) begin
                stage_hex   <= hex_in;
                stage_dp    <= dp_in;
                stage_blank <= blank_in;
                pending     <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an        <= '1;
            hex       <= 4'h0;
            dp        <= 1'b1;
            digit_idx <= '0;
        end else begin
            an        <= an_next;
            hex       <= disp_hex[idx];
            dp        <= disp_dp[idx];
            digit_idx <= idx;
        end
    end

endmodule

// File: tb/tb_disp_hex_mux.sv
// Bench for disp_hex_mux: a cycle-level reference model pushes the expected
// outputs each clock and a negedge monitor pops and compares them.
module tb_disp_hex_mux;

    localparam int N     = 4;
    localparam int PB    = 2;
    localparam int SLOT  = 1 << PB;
    localparam int FRAME = N * SLOT;
    localparam int EW    = N + 4 + 1 + 2 + 1 + 1;

    logic           clk;
    logic           reset;
    logic [4*N-1:0] hex_in;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   blank_in;
    logic           load;
    logic           lz_en;
    logic           load_ack;
    logic           pending;
    logic [N-1:0]   an;
    logic [3:0]     hex;
    logic           dp;
    logic [1:0]     digit_idx;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    disp_hex_mux #(.N_DIGITS(N), .PRESCALE_BITS(PB)) dut (
        .clk       (clk),
        .reset     (reset),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .load      (load),
        .lz_en     (lz_en),
        .load_ack  (load_ack),
        .pending   (pending),
        .an        (an),
        .hex       (hex),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position in the frame is just a cycle count since
    // reset; slot and frame boundaries fall out of division and modulo.
    int         m_cyc;
    logic [3:0] m_stage_hex[N];
    logic       m_stage_dp[N];
    logic       m_stage_blank[N];
    logic [3:0] m_disp_hex[N];
    logic       m_disp_dp[N];
    logic       m_disp_blank[N];
    logic       m_pending;

    always @(posedge clk) begin
        int         d;
        int         msd;
        logic       is_dark;
        logic       fe;
        logic       ack;
        logic [N-1:0] e_an;
        logic [3:0] e_hex;
        logic       e_dp;
        if (reset) begin
            m_cyc     = 0;
            m_pending = 1'b0;
            for (int j = 0; j < N; j++) begin
                m_stage_hex[j] = 4'h0; m_stage_dp[j] = 1'b1; m_stage_blank[j] = 1'b0;
                m_disp_hex[j]  = 4'h0; m_disp_dp[j]  = 1'b1; m_disp_blank[j]  = 1'b0;
            end
            exp_q.push_back({{N{1'b1}}, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0});
        end else begin
            d     = (m_cyc / SLOT) % N;
            e_hex = m_disp_hex[d];
            e_dp  = m_disp_dp[d];
            msd   = -1;
            for (int j = 0; j < N; j++) begin
                if (m_disp_hex[j] != 4'h0 || !m_disp_dp[j]) msd = j;
            end
            is_dark = m_disp_blank[d] || (lz_en && d != 0 && d > msd);
            e_an = '1;
            if (!is_dark) e_an[d] = 1'b0;
            fe  = ((m_cyc % FRAME) == FRAME - 1);
            ack = fe && m_pending;
            if (ack) begin
                for (int j = 0; j < N; j++) begin
                    m_disp_hex[j]   = m_stage_hex[j];
                    m_disp_dp[j]    = m_stage_dp[j];
                    m_disp_blank[j] = m_stage_blank[j];
                end
            end
            if (load) begin
                for (int j = 0; j < N; j++) begin
                    m_stage_hex[j]   = hex_in[4*j +: 4];
                    m_stage_dp[j]    = dp_in[j];
                    m_stage_blank[j] = blank_in[j];
                end
                m_pending = 1'b1;
            end else if (ack) begin
                m_pending = 1'b0;
            end
            m_cyc = (m_cyc + 1) % FRAME;
            exp_q.push_back({e_an, e_hex, e_dp, 2'(d), m_pending, ack});
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {an, hex, dp, digit_idx, pending, load_ack};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got an=%b hex=%h dp=%b idx=%0d pend=%b ack=%b exp an=%b hex=%h dp=%b idx=%0d pend=%b ack=%b",
                         $time, an, hex, dp, digit_idx, pending, load_ack,
                         e[EW-1 -: N], e[8:5], e[4], e[3:2], e[1], e[0]);
            end
            checks++;
            if ($countones(~an) > 1) begin
                failures++;
                $display("FAIL an_onehot t=%0t got an=%b exp at most one low bit", $time, an);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (m_cyc != target && n < 4 * FRAME) begin
            step(1);
            n++;
        end
        if (m_cyc != target) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc got cyc=%0d exp cyc=%0d", m_cyc, target);
        end
    endtask

    task automatic do_load(input logic [4*N-1:0] h, input logic [N-1:0] d,
                           input logic [N-1:0] b);
        hex_in   = h;
        dp_in    = d;
        blank_in = b;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    function automatic logic [4*N-1:0] rand_hex();
        logic [4*N-1:0] h;
        for (int j = 0; j < N; j++) begin
            h[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        end
        return h;
    endfunction

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        lz_en    = 1'b0;
        hex_in   = '0;
        dp_in    = '1;
        blank_in = '0;
        step(3);
        reset = 1'b0;

        // scan order
        step(2 * FRAME);

        // commit timing: load while digit 1 is selected
        wait_cyc(4);
        do_load(16'h1234, 4'b1011, 4'b0000);
        step(2 * FRAME);

        // double load before a frame boundary
        wait_cyc(2);
        do_load(16'hAAAA, 4'hF, 4'h0);
        wait_cyc(10);
        do_load(16'h5555, 4'hF, 4'h0);
        step(2 * FRAME);

        // load coincident with frame_end
        wait_cyc(3);
        do_load(16'h1111, 4'hF, 4'h0);
        wait_cyc(FRAME - 1);
        do_load(16'h0F0F, 4'hF, 4'h0);
        step(3 * FRAME);

        // leading zeros
        lz_en = 1'b1;
        do_load(16'h0040, 4'hF, 4'h0);
        step(2 * FRAME);
        do_load(16'h0040, 4'b0111, 4'h0);
        step(2 * FRAME);
        do_load(16'h0000, 4'hF, 4'h0);
        step(2 * FRAME);
        lz_en = 1'b0;
        step(FRAME);

        // explicit blanking
        do_load(16'h8421, 4'hF, 4'b0101);
        step(2 * FRAME);

        // reset while data is pending at digit 2
        wait_cyc(5);
        do_load(16'h9876, 4'h0, 4'h0);
        wait_cyc(8);
        pulse_reset();
        step(2 * FRAME);

        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 20));
            if ($urandom_range(0, 9) == 0) pulse_reset();
            lz_en = 1'($urandom_range(0, 1));
            do_load(rand_hex(), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        step(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_hex_mux.md
Name: disp_hex_mux

Overview:
Time-multiplexed driver for the board's common-anode seven-segment display. It sits directly upstream of the hex-to-segment decoder. Each refresh slot it selects one digit's nibble and decimal point and drives that digit's anode low. New display values are double-buffered and committed only at a frame boundary, so the display never shows a mix of old and new digits. It also provides optional leading-zero suppression.

Parameters:
N_DIGITS, 4, number of digits (range 2..8).
PRESCALE_BITS, 18, width of the refresh prescaler; each digit is shown for 2^PRESCALE_BITS clocks (minimum 2).

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
hex_in  in  4*N_DIGITS  digit nibbles; digit 0 is bits [3:0] and is the rightmost digit.
dp_in  in  N_DIGITS  decimal points, active-low (0 = lit).
blank_in  in  N_DIGITS  1 = force that digit dark.
load  in  1  one-cycle strobe that captures hex_in, dp_in and blank_in into staging.
lz_en  in  1  leading-zero suppression enable (level, sampled live).
load_ack  out  1  one-cycle pulse when staged data is committed to the display.
pending  out  1  staged data is waiting for the next frame boundary.
an  out  N_DIGITS  anodes, active-low, at most one bit low.
hex  out  4  nibble to the decoder.
dp  out  1  active-low decimal point to the decoder.
digit_idx  out  clog2(N_DIGITS)  digit currently driven on an/hex/dp.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous, active-high, and all state is sampled on the rising clk edge.
  - Reset values: prescaler=0, idx=0, pending=0, load_ack=0.
  - Reset values for display and staging registers: hex 0, dp all 1, blank all 0.
  - Reset values for outputs: an all 1, hex=0, dp=1, digit_idx=0.
  - Asserting reset mid-frame or with data pending discards the staged data; no ack is issued.
- Prescaler:
  - Free-running up-counter, wraps 2^PRESCALE_BITS-1 -> 0.
  - tick = (prescaler == all ones).
  - On tick: idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
  - frame_end = tick && idx==N_DIGITS-1.
- Output stage:
  - an, hex, dp and digit_idx are registered and reflect the idx/display state of the previous cycle (1-cycle latency).
  - For the selected digit d: hex=disp_hex[d], dp=disp_dp[d].
  - an = all ones except bit d = 0, unless digit d is dark, in which case an = all ones.
  - hex and dp are still driven normally when the digit is dark.
- Dark rule: digit d is dark if disp_blank[d]=1, or if the leading-zero condition holds.
  - Leading-zero condition: lz_en=1, d != 0, and for every j >= d: disp_hex[j]==0, disp_dp[j]==1 and disp_blank[j] is ignored.
  - Digit 0 is never suppressed by lz_en.
- Load handshake:
  - load=1 writes the inputs into staging and sets pending=1. A later load before commit overwrites staging (last write wins).
  - On frame_end with pending=1: display <= staging, pending <= 0, load_ack=1 for exactly one cycle.
  - The new data is visible from the next slot, which is digit 0.
  - load coincident with frame_end: the commit uses the staging contents from before this cycle. The new data is written into staging, pending stays 1, and load_ack still pulses.
  - frame_end with pending=0: no change, load_ack=0.
- Widths:
  - hex_in is sliced on 4-bit boundaries.
  - digit_idx is zero-extended; for N_DIGITS=2 its width is 1.
  - idx never takes a value >= N_DIGITS.

Test Plan:
1. Scan order, N_DIGITS=4, PRESCALE_BITS=2, after reset release:
   - Cycle 1: an=1110, digit_idx=0.
   - an sequence 1110, 1101, 1011, 0111, each held for 4 cycles, then wraps to 1110.
   - Never more than one an bit low.
2. Commit timing:
   - Drive load with hex_in=16'h1234, dp_in=4'b1011 while idx=1.
   - pending=1 until frame_end; load_ack pulses once at frame_end.
   - Next slot is digit 0 showing hex=4, dp=1; digit 2 shows hex=2, dp=0.
   - Before the commit, old values (0) are shown.
3. Double load:
   - load 16'hAAAA, then load 16'h5555 before frame_end.
   - Only 5 is ever displayed; exactly one load_ack.
4. Load coincident with frame_end:
   - Load 16'h0F0F exactly on the frame_end cycle, with staging previously holding 16'h1111.
   - Frame k+1 displays 1111; pending remains 1.
   - Frame k+2 displays 0F0F with a second load_ack.
5. Leading zeros:
   - Display 16'h0040 with dp all 1, lz_en=1: digits 3 and 2 dark (an stays 1111 in their slots); digits 1 and 0 lit.
   - Set dp_in[3]=0: digits 3..0 all lit.
   - Display 16'h0000 with lz_en=1: only digit 0 lit.
6. Reset mid-operation:
   - Assert reset for 1 cycle with pending=1 at idx=2.
   - Next cycle: an=1111, digit_idx=0, pending=0, no load_ack.
   - Display shows hex 0 with dp off.
